uart_rx_engine: RTL and testbench
=================================

# uart_rx_engine

Oversampling UART receive engine that sits directly downstream of the baud-rate divider in the UART controller and directly upstream of the RX AXI-Stream FIFO. It synchronises the asynchronous `rx_uart` line and detects start bits on the 16x `clk_enable` tick. It samples data, optional parity and stop bits at mid-bit, then emits one single-cycle `rx_data_valid` pulse per frame with the received byte and an error flag. It has no backpressure: the downstream FIFO must accept every pulse.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `OVERSAMPLE`, default 16: `clk_enable` ticks per bit. It must be even and at least 8.
- `clk`  input  1  system clock; one clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `clk_enable`  input  1  oversample tick, one `clk` cycle wide, `OVERSAMPLE` per bit period.
- `parity_en`  input  1  selects even parity after the data bits; latched at start-bit acceptance.
- `rx_uart`  input  1  asynchronous serial line, idle high.
- `rx_data_valid`  output  1  one-cycle pulse, one per completed frame.
- `rx_data`  output  `DATA_BITS`  received byte; holds until the next pulse.
- `rx_data_error`  output  1  parity or framing error for the current `rx_data`; valid with the pulse and held with `rx_data`.
- `rx_break`  output  1  level; high while a break condition persists.

## Operation
- Input synchroniser: `rx_uart` passes through a 2-flop synchroniser, both flops reset to 1. All logic uses the synchronised value `rxs`.
- Tick counter: `tick`, width `$clog2(OVERSAMPLE)`, advances only on `clk_enable` and wraps from `OVERSAMPLE-1` to 0. Tick 0 is the first bit tick. The mid-bit decision point is M = `OVERSAMPLE/2-1`; with macro, M+1.
- Bit counter: counts 0..`DATA_BITS-1` and is cleared on entry to DATA.
- State machine; every transition occurs only on a `clk_enable` cycle:
  - WAIT_HIGH: the reset state. Go to IDLE when `rxs`=1.
  - IDLE: when `rxs`=0, clear `tick` to 0, latch `parity_en`, go to START.
  - START: at the decision point, a sampled 1 is a false start: go to IDLE with no output. A sampled 0 continues; at tick wrap go to DATA.
  - DATA: at each decision point, shift the sample into the data register at the MSB position, so data arrives LSB first. At the wrap after bit `DATA_BITS-1`, go to PARITY if the latched parity is enabled, else STOP.
  - PARITY: at the decision point, set `perr` = XOR of data bits XOR the sampled bit, which gives even parity. At wrap go to STOP.
  - STOP: at the decision point, set `ferr` = ~sample, then commit the frame. If `ferr`=1 and data is all zero, set `rx_break`=1 and go to WAIT_HIGH. Otherwise go to IDLE immediately at mid-stop, allowing resynchronisation to the next start edge.
- Commit: `rx_data` is loaded, `rx_data_error` = `perr` | `ferr`, and `rx_data_valid` is pulsed.
- `rx_break` clears on the `clk_enable` cycle where WAIT_HIGH sees `rxs`=1.
- Frames are always emitted, including errored ones. Downstream uses `rx_data_error` as `tkeep`.

## Timing
- Reset values: `rx_data_valid`=0, `rx_data`=0, `rx_data_error`=0, `rx_break`=0. State=WAIT_HIGH, synchroniser flops=1, counters=0, `perr`/`ferr`=0.
- Input latency: 2 `clk` cycles of synchroniser delay before `rx_uart` changes reach the FSM.
- Commit latency: `rx_data_valid` is registered and high for exactly the one `clk` cycle following the `clk_enable` cycle of the stop-bit decision. `rx_data` and `rx_data_error` update in that same cycle.
- Frame spacing: the minimum spacing between pulses equals the frame length minus half a bit. Back-to-back frames with no idle are supported.
- `clk_enable` low: the state and all counters hold.
- `parity_en` changes mid-frame have no effect until the next start.
- Reset mid-frame: the partial frame is discarded with no pulse, and the FSM restarts in WAIT_HIGH.
- `clk_enable` asserted continuously: behaves as `OVERSAMPLE` `clk` cycles per bit.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined: each bit decision is the 2-of-3 majority of `rxs` at ticks M-1, M and M+1, where M = `OVERSAMPLE/2-1`. The decision is taken at tick M+1.
- Undefined: each bit decision is the single sample of `rxs` at tick M.
- All other behaviour is identical either way. With the macro defined, commit occurs one tick later.

## Test plan
- Byte 0xA5, `parity_en`=0, `clk_enable` every 4 `clk` -> one pulse, `rx_data`=0xA5, `rx_data_error`=0, `rx_break`=0.
- Byte 0x3C, `parity_en`=1, parity bit 0 -> `rx_data`=0x3C, error=0. Repeat with parity bit 1 -> `rx_data`=0x3C, error=1.
- Byte 0x55 with stop bit driven 0 for one bit then high -> `rx_data`=0x55, error=1, `rx_break` stays 0. Then line held low for 20 bit times -> `rx_data`=0x00, error=1, `rx_break`=1 until the line goes high.
- Low glitch of 3 ticks on an idle line -> no pulse, FSM back in IDLE. A following valid 0x81 frame is received correctly.
- Reset asserted mid-DATA of a 0xFF frame with the line released high -> no pulse, all outputs 0. The next 0x12 frame gives `rx_data`=0x12.
- Macro defined: byte 0x00 with a 1-tick high glitch exactly at tick M of bit 3 -> `rx_data`=0x00. Macro undefined, same stimulus -> `rx_data`=0x08.

Source files
------------

// File: rtl/uart_rx_engine_if.sv
// uart_rx_engine_if
//   Output bundle of the UART receive engine toward the RX stream FIFO.
//   master : driven by uart_rx_engine
//   slave  : consumed by the FIFO / any observer
// Signals:
//   rx_data_valid  one-cycle pulse per completed frame
//   rx_data        received byte, held until the next pulse
//   rx_data_error  parity or framing error for rx_data (used as tkeep downstream)
//   rx_break       level, high while a break condition persists
interface uart_rx_engine_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_data_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_error;
  logic                 rx_break;

  modport master (
    output rx_data_valid,
    output rx_data,
    output rx_data_error,
    output rx_break
  );

  modport slave (
    input rx_data_valid,
    input rx_data,
    input rx_data_error,
    input rx_break
  );
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine
//   Oversampling UART receiver: 2-flop input synchroniser, start-bit detection
//   on the clk_enable tick, mid-bit sampling of data / optional even parity /
//   stop, and one registered rx_data_valid pulse per frame (errored frames
//   included). No backpressure.
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   clk_enable  oversample tick, OVERSAMPLE per bit period
//   parity_en   even parity after the data bits, latched at start acceptance
//   rx_uart     asynchronous serial line, idle high
//   rx_o        output bundle (uart_rx_engine_if.master)
// Build option:
//   UART_RX_MAJORITY_VOTE_EN  when defined, each bit decision is the 2-of-3
//   majority of the samples at ticks M-1, M, M+1 (decision taken at M+1);
//   otherwise a single sample at tick M. M = OVERSAMPLE/2-1.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_HIGH | after reset or break: wait for the line to return high
// IDLE      | line idle, looking for a falling edge (start bit)
// START     | validating the start bit at mid-bit
// DATA      | sampling DATA_BITS data bits, LSB first
// PARITY    | sampling the even-parity bit
// STOP      | sampling the stop bit, commit the frame at mid-stop
module uart_rx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             parity_en,
  input  logic             rx_uart,
  uart_rx_engine_if.master rx_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int M  = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int DEC = M + 1;
`else
  localparam int DEC = M;
`endif
  localparam logic [TW-1:0] TICK_DEC  = TW'(DEC);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rxs_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 err_q, err_d;
  logic                 brk_q, brk_d;

  logic                 sample;
  logic                 at_dec;
  logic                 at_last;
  logic [DATA_BITS:0]   shift_in;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // hist_q[0] holds rxs from the previous tick, hist_q[1] from two ticks ago,
  // so at the decision tick (M+1) they cover ticks M and M-1.
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else if (clk_enable) begin
      hist_q <= {hist_q[0], rxs_q};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
  assign sample = rxs_q;
`endif

  assign at_dec   = (tick_q == TICK_DEC);
  assign at_last  = (tick_q == TICK_LAST);
  // New sample enters at the MSB; after DATA_BITS shifts the first bit is the LSB.
  assign shift_in = {sample, shift_q};

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;
    rx_data_d = rx_data_q;
    err_d     = err_q;
    brk_d     = brk_q;

    if (clk_enable) begin
      tick_d = at_last ? '0 : tick_q + 1'b1;

      unique case (state_q)
        S_WAIT_HIGH: begin
          if (rxs_q) begin
            brk_d   = 1'b0;
            state_d = S_IDLE;
          end
        end

        S_IDLE: begin
          if (!rxs_q) begin
            tick_d   = '0;
            par_en_d = parity_en;
            perr_d   = 1'b0;
            ferr_d   = 1'b0;
            state_d  = S_START;
          end
        end

        S_START: begin
          if (at_dec && sample) begin
            state_d = S_IDLE;
          end else if (at_last) begin
            bit_d   = '0;
            state_d = S_DATA;
          end
        end

        S_DATA: begin
          if (at_dec) begin
            shift_d = shift_in[DATA_BITS:1];
          end
          if (at_last) begin
            if (bit_q == BIT_LAST) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (at_dec) begin
            perr_d = (^shift_q) ^ sample;
          end
          if (at_last) begin
            state_d = S_STOP;
          end
        end

        S_STOP: begin
          if (at_dec) begin
            ferr_d    = ~sample;
            valid_d   = 1'b1;
            rx_data_d = shift_q;
            err_d     = perr_q | ferr_d;
            // A low stop bit with all-zero data means the line is held low.
            if (ferr_d && (shift_q == '0)) begin
              brk_d   = 1'b1;
              state_d = S_WAIT_HIGH;
            end else begin
              // Leave at mid-stop so the next start edge is caught early.
              state_d = S_IDLE;
            end
          end
        end

        default: state_d = S_WAIT_HIGH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_WAIT_HIGH;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      rx_data_q <= '0;
      err_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_uart;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
      rx_data_q <= rx_data_d;
      err_q     <= err_d;
      brk_q     <= brk_d;
    end
  end

  assign rx_o.rx_data_valid = valid_q;
  assign rx_o.rx_data       = rx_data_q;
  assign rx_o.rx_data_error = err_q;
  assign rx_o.rx_break      = brk_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Testbench for uart_rx_engine: directed frames, scoreboard queue filled at
// stimulus time, separate monitor popping on every rx_data_valid pulse.
// One "slot" is one clk_enable tick; a value driven right after a tick is the
// value the FSM sees on the following tick (2-flop synchroniser < 4 clk).
module tb_uart_rx_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce = 1'b0;
  logic [1:0] ce_div = 2'd0;
  logic       parity_en;
  logic       rx_uart;

  uart_rx_engine_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_engine #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(ce),
    .parity_en (parity_en),
    .rx_uart   (rx_uart),
    .rx_o      (rx_if)
  );

  always #5 clk = ~clk;

  // clk_enable: one clk cycle high every 4, changed away from the active edge
  always @(negedge clk) begin
    ce_div <= ce_div + 2'd1;
    ce     <= (ce_div == 2'd3);
  end

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic       brk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  bit   chk_width = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (chk_width) begin
      chk_width = 1'b0;
      check("pulse_width", {31'd0, rx_if.rx_data_valid}, 32'd0);
    end
    if (rx_if.rx_data_valid === 1'b1) begin
      pulses++;
      chk_width = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got data %0h expected no pulse", rx_if.rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", {24'd0, rx_if.rx_data}, {24'd0, e.data});
        check("rx_data_error", {31'd0, rx_if.rx_data_error}, {31'd0, e.err});
        check("rx_break_at_pulse", {31'd0, rx_if.rx_break}, {31'd0, e.brk});
      end
    end
  end

  task automatic drive_slot(input logic v);
    rx_uart = v;
    do @(posedge clk); while (ce !== 1'b1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_slot(1'b1);
  endtask

  task automatic push(input logic [7:0] d, input logic err, input logic brk);
    exp_t e;
    e.data = d;
    e.err  = err;
    e.brk  = brk;
    exp_q.push_back(e);
  endtask

  // Full frame; glitch inverts one slot, pflip toggles parity_en at one slot
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                            input bit stop, input int glitch, input int pflip);
    int n;
    int b;
    logic v;
    parity_en = pen;
    n = 16 * (pen ? 11 : 10);
    for (int s = 0; s < n; s++) begin
      b = s / 16;
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else if (pen && b == 9) v = pbit;
      else v = stop;
      if (s == glitch) v = ~v;
      if (s == pflip) parity_en = ~parity_en;
      drive_slot(v);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    rx_uart   = 1'b1;
    parity_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, rx_if.rx_data_valid}, 32'd0);
    check("reset_data",  {24'd0, rx_if.rx_data}, 32'd0);
    check("reset_error", {31'd0, rx_if.rx_data_error}, 32'd0);
    check("reset_break", {31'd0, rx_if.rx_break}, 32'd0);
    reset = 1'b0;
    idle(24);

    // 0xA5, no parity; parity_en toggled mid-frame must be ignored
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, 40);
    parity_en = 1'b0;
    idle(24);
    check("data_hold", {24'd0, rx_if.rx_data}, 32'hA5);

    // 0x3C with even parity: correct then wrong parity bit
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, -1);
    idle(24);
    push(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, -1);
    parity_en = 1'b0;
    idle(24);

    // 0x55 with low stop bit: framing error, not a break
    push(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, -1);
    idle(24);
    check("no_break_after_ferr", {31'd0, rx_if.rx_break}, 32'd0);

    // Line held low for 20 bit times: break
    push(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 320; i++) drive_slot(1'b0);
    check("break_held", {31'd0, rx_if.rx_break}, 32'd1);
    idle(4);
    check("break_released", {31'd0, rx_if.rx_break}, 32'd0);
    idle(24);

    // 3-tick low glitch: false start, then a good 0x81
    for (int i = 0; i < 3; i++) drive_slot(1'b0);
    idle(40);
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(24);

    // Reset in the middle of a 0xFF frame, then 0x12
    for (int i = 0; i < 16; i++) drive_slot(1'b0);
    for (int i = 0; i < 30; i++) drive_slot(1'b1);
    rx_uart = 1'b1;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_valid", {31'd0, rx_if.rx_data_valid}, 32'd0);
    check("midreset_data",  {24'd0, rx_if.rx_data}, 32'd0);
    check("midreset_error", {31'd0, rx_if.rx_data_error}, 32'd0);
    check("midreset_break", {31'd0, rx_if.rx_break}, 32'd0);
    reset = 1'b0;
    idle(24);
    push(8'h12, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(24);

    // 0x00 with a 1-tick high glitch at the decision tick M of bit 3 (slot 72)
`ifdef UART_RX_MAJORITY_VOTE_EN
    push(8'h00, 1'b0, 1'b0);
`else
    push(8'h08, 1'b0, 1'b0);
`endif
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 72, -1);
    idle(40);

    check("queue_empty", exp_q.size(), 32'd0);
    check("pulse_count", pulses, 32'd8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
